// File: rtl/multiplier_seq_pkg.sv
// rtl/multiplier_seq_pkg.sv - shared constants and helpers for multiplier_seq
// Build option: MUL_RADIX4_EN retires two multiplier bits per CALC cycle.
`include "riscv_defines.svh"

package multiplier_seq_pkg;

  localparam int XLEN = 32;

`ifdef MUL_RADIX4_EN
  localparam int MUL_STEP = 2;
`else
  localparam int MUL_STEP = 1;
`endif

  localparam int MUL_ITERS = XLEN / MUL_STEP;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  typedef logic [`MUL_OP_WIDTH-1:0] mul_op_t;

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_operand_prep.sv
// rtl/mul_operand_prep.sv - combinational operand conditioning for multiplier_seq
module mul_operand_prep
  import multiplier_seq_pkg::*;
(
  input  logic [`MUL_OP_WIDTH-1:0] MULop,
  input  logic [XLEN-1:0]          factor1,
  input  logic [XLEN-1:0]          factor2,
  output logic [XLEN-1:0]          abs_a,
  output logic [XLEN-1:0]          abs_b,
  output logic                     neg,
  output logic                     hi_sel
);

  logic a_signed;
  logic b_signed;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    hi_sel   = 1'b1;
    case (MULop)
      `MUL_OP_MUL:   hi_sel = 1'b0;
      `MUL_OP_MULH:  begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      `MUL_OP_MULSU: a_signed = 1'b1;
      default:       ;
    endcase
  end

  assign abs_a = magnitude(factor1, a_signed);
  assign abs_b = magnitude(factor2, b_signed);
  assign neg   = (a_signed & factor1[XLEN-1]) ^ (b_signed & factor2[XLEN-1]);

endmodule

// File: rtl/riscv_defines.svh
// rtl/riscv_defines.svh - RV32M multiply opcode encodings shared with the multiplier decoder
`ifndef RISCV_DEFINES_SVH
`define RISCV_DEFINES_SVH

`define MUL_OP_WIDTH 2
`define MUL_OP_MUL   2'd0
`define MUL_OP_MULH  2'd1
`define MUL_OP_MULSU 2'd2
`define MUL_OP_MULU  2'd3

`endif

// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU)
// Build option: MUL_RADIX4_EN halves the CALC phase to 16 cycles.
module multiplier_seq
  import multiplier_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          factor1,
  input  logic [XLEN-1:0]          factor2,
  input  logic [`MUL_OP_WIDTH-1:0] MULop,
  input  logic                     mul_valid,
  output logic                     mul_ready,
  output logic [XLEN-1:0]          product
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} mul_state_t;

  mul_state_t          state;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic                neg;
  logic                hi_sel;

  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic                neg_q;
  logic                hi_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   partial;
  logic [2*XLEN-1:0]   signed_acc;

  mul_operand_prep u_prep (
    .MULop   (MULop),
    .factor1 (factor1),
    .factor2 (factor2),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .neg     (neg),
    .hi_sel  (hi_sel)
  );

  // mcand is pre-shifted each cycle, so the partial product needs no barrel shift by cnt
  always_comb begin
`ifdef MUL_RADIX4_EN
    partial = (mplier[0] ? mcand : '0) + (mplier[1] ? {mcand[2*XLEN-2:0], 1'b0} : '0);
`else
    partial = mplier[0] ? mcand : '0;
`endif
    signed_acc = neg_q ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mul_ready <= 1'b0;
      product   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      neg_q     <= 1'b0;
      hi_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      mul_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_valid) begin
            mcand  <= {{XLEN{1'b0}}, abs_a};
            mplier <= abs_b;
            neg_q  <= neg;
            hi_q   <= hi_sel;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc + partial;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(MUL_ITERS - 1)) state <= SIGN;
        end
        SIGN: begin
          product   <= hi_q ? signed_acc[2*XLEN-1:XLEN] : signed_acc[XLEN-1:0];
          mul_ready <= 1'b1;
          state     <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// tb/tb_multiplier_seq.sv - self-checking bench for multiplier_seq
module tb_multiplier_seq;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULH  = 2'd1;
  localparam logic [1:0] OP_MULSU = 2'd2;
  localparam logic [1:0] OP_MULU  = 2'd3;
`ifdef MUL_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] factor1 = '0;
  logic [31:0] factor2 = '0;
  logic [1:0]  MULop = '0;
  logic        mul_valid = 1'b0;
  logic        mul_ready;
  logic [31:0] product;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int ready_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  multiplier_seq dut (
    .clk       (clk),
    .rst       (rst),
    .factor1   (factor1),
    .factor2   (factor2),
    .MULop     (MULop),
    .mul_valid (mul_valid),
    .mul_ready (mul_ready),
    .product   (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] p;
    sa = (op == OP_MULH || op == OP_MULSU) ? {{34{a[31]}}, a} : {34'd0, a};
    sb = (op == OP_MULH) ? {{34{b[31]}}, b} : {34'd0, b};
    p  = sa * sb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    factor1   = a;
    factor2   = b;
    MULop     = op;
    mul_valid = 1'b1;
    start_cyc = cyc;
    if (push) exp_q.push_back(ref_mul(op, a, b));
  endtask

  task automatic wait_result(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (mul_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (mul_ready !== 1'b1) begin
      check({tag, "_timeout"}, {31'd0, mul_ready}, 32'd1);
    end else begin
      ready_cyc = cyc;
      check({tag, "_latency"}, 32'(cyc - start_cyc), 32'(LAT));
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, product, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        check({tag, "_product"}, product, e);
      end
      @(negedge clk);
      check({tag, "_pulse_width"}, {31'd0, mul_ready}, 32'd0);
    end
    mul_valid = 1'b0;
  endtask

  initial begin
    int r1;
    bit seen;
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0001_0000;

    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, mul_ready}, 32'd0);
    check("reset_product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op(OP_MUL, 32'd7, 32'd6, 1);           wait_result("mul_7x6");
    check("mul_7x6_const", product, 32'h0000_002A);
    start_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);  wait_result("mulh_m1");
    start_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 1);  wait_result("mulh_min");
    check("mulh_min_const", product, 32'h4000_0000);
    start_op(OP_MULH, 32'h8000_0000, 32'h0000_0001, 1);  wait_result("mulh_min_x1");
    check("mulh_min_x1_const", product, 32'hFFFF_FFFF);
    start_op(OP_MULSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_result("mulsu_m1");
    check("mulsu_m1_const", product, 32'hFFFF_FFFF);
    start_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);  wait_result("mulu_m1");
    check("mulu_m1_const", product, 32'hFFFF_FFFE);
    start_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);   wait_result("mul_m1");
    check("mul_m1_const", product, 32'h0000_0001);
    start_op(OP_MULH, 32'h0000_0000, 32'h8000_0000, 1);  wait_result("zero_op");

    repeat (5) @(negedge clk);
    check("product_hold", product, last_exp);

    // reset mid-operation: discarded op, no pulse, product cleared
    start_op(OP_MULU, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    mul_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_product", product, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_ready === 1'b1) seen = 1'b1;
    end
    check("rst_mid_no_ready", {31'd0, seen}, 32'd0);
    start_op(OP_MULH, 32'hFFFF_FFF9, 32'h0000_0003, 1);  wait_result("after_rst");

    // back-to-back issue
    start_op(OP_MULU, 32'd3, 32'd5, 1);
    wait_result("b2b_first");
    check("b2b_first_const", product, 32'h0000_0000);
    r1 = ready_cyc;
    start_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1);
    wait_result("b2b_second");
    check("b2b_second_const", product, 32'h0000_0000);
    check("b2b_interval", 32'(ready_cyc - r1), 32'(LAT + 1));

    // inputs changing and valid dropping mid-operation
    start_op(OP_MULSU, 32'h8765_4321, 32'h0F0F_1234, 1);
    repeat (5) @(negedge clk);
    mul_valid = 1'b0;
    factor1   = 32'h1111_1111;
    factor2   = 32'h2222_2222;
    MULop     = OP_MUL;
    wait_result("mid_change");

    for (int k = 0; k < 30; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      start_op(2'($urandom_range(0, 3)), a, b, 1);
      wait_result("random");
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
